// File: rtl/phase_sequencer_if.sv
// Strobe/phase request and CORDIC-side output bundle for phase_sequencer.
interface phase_sequencer_if #(
    parameter int unsigned BW = 8
);
    logic          enable_i;
    logic          strobe_i;
    logic [BW-1:0] phase_inc_i;
    logic          phase_clr_i;
    logic          ready_i;
    logic          overrun_clr_i;
    logic [BW-1:0] angle_o;
    logic          negate_o;
    logic          valid_o;
    logic          wrap_o;
    logic          overrun_o;

    modport master (
        output enable_i, strobe_i, phase_inc_i, phase_clr_i, ready_i, overrun_clr_i,
        input  angle_o, negate_o, valid_o, wrap_o, overrun_o
    );

    modport slave (
        input  enable_i, strobe_i, phase_inc_i, phase_clr_i, ready_i, overrun_clr_i,
        output angle_o, negate_o, valid_o, wrap_o, overrun_o
    );
endinterface

// File: rtl/phase_sequencer.sv
// Phase accumulator that folds each sampled phase into the CORDIC convergence
// range and hands it downstream over a valid/ready handshake.
module phase_sequencer #(
    parameter int unsigned BW = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    phase_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, PENDING} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] acc_q, acc_d;
    logic [BW-1:0] angle_q, angle_d;
    logic          negate_q, negate_d;
    logic          valid_q, valid_d;
    logic          wrap_q, wrap_d;
    logic          overrun_q, overrun_d;
    logic [BW:0]   sum_c;
    logic          strobe_c;
    logic          accept_c;
    logic          drop_c;
    logic          flip_c;

    // State register and registered outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            angle_q   <= '0;
            negate_q  <= 1'b0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            angle_q   <= angle_d;
            negate_q  <= negate_d;
            valid_q   <= valid_d;
            wrap_q    <= wrap_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state, accumulator and output update
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        angle_d   = angle_q;
        negate_d  = negate_q;
        wrap_d    = 1'b0;
        overrun_d = overrun_q;
        accept_c  = 1'b0;
        drop_c    = 1'b0;
        sum_c     = (BW+1)'(acc_q) + (BW+1)'(bus.phase_inc_i);
        // Quadrants 01/10 lie outside the convergence range: rotate by half a turn
        flip_c    = acc_q[BW-1] ^ acc_q[BW-2];
        // A coincident clear swallows the strobe entirely
        strobe_c  = bus.strobe_i & ~bus.phase_clr_i & bus.enable_i;

        case (state_q)
            IDLE: begin
                if (bus.enable_i) state_d = ARMED;
            end
            ARMED: begin
                if (strobe_c) begin
                    accept_c = 1'b1;
                    state_d  = PENDING;
                end
            end
            PENDING: begin
                if (strobe_c && bus.ready_i) begin
                    accept_c = 1'b1;
                end else if (strobe_c) begin
                    drop_c = 1'b1;
                end else if (bus.ready_i) begin
                    state_d = ARMED;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!bus.enable_i) state_d = IDLE;

        if (accept_c) begin
            acc_d    = sum_c[BW-1:0];
            wrap_d   = sum_c[BW];
            angle_d  = {acc_q[BW-1] ^ flip_c, acc_q[BW-2:0]};
            negate_d = flip_c;
        end
        if (bus.phase_clr_i) acc_d = '0;

        if (bus.overrun_clr_i) overrun_d = 1'b0;
        if (drop_c)            overrun_d = 1'b1;

        valid_d = (state_d == PENDING);
    end

    assign bus.angle_o   = angle_q;
    assign bus.negate_o  = negate_q;
    assign bus.valid_o   = valid_q;
    assign bus.wrap_o    = wrap_q;
    assign bus.overrun_o = overrun_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized and scenario-driven bench for phase_sequencer against a
// queue-based behavioural model of the phase/handshake rules.
module tb_phase_sequencer;
    localparam int unsigned BW   = 8;
    localparam int          FULL = 1 << BW;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    phase_sequencer_if #(.BW(BW)) bus ();

    phase_sequencer #(.BW(BW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Model: phase value, "enabled long enough to arm", one-deep output queue
    int m_phase  = 0;
    bit m_active = 0;
    int m_outq[$];
    bit m_wrap   = 0;
    bit m_ov     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Encodes negate*FULL + angle for a given phase
    function automatic int map_phase(input int p);
        int quad = p / (FULL / 4);
        if (quad == 1 || quad == 2) return FULL + ((p + FULL / 2) % FULL);
        return p;
    endfunction

    task automatic model_reset();
        m_phase  = 0;
        m_active = 0;
        m_outq.delete();
        m_wrap   = 0;
        m_ov     = 0;
    endtask

    task automatic model_edge(input bit en, input bit stb, input int inc,
                              input bit clr, input bit rdy, input bit oclr);
        bit dropped = 0;
        m_wrap = 0;
        if (!en) begin
            m_active = 0;
            m_outq.delete();
        end else if (!m_active) begin
            m_active = 1;
        end else if (stb && !clr) begin
            if (m_outq.size() == 0 || rdy) begin
                m_outq.delete();
                m_outq.push_back(map_phase(m_phase));
                m_wrap  = (m_phase + inc) >= FULL;
                m_phase = (m_phase + inc) % FULL;
            end else begin
                dropped = 1;
            end
        end else if (rdy) begin
            m_outq.delete();
        end
        if (clr) m_phase = 0;
        if (dropped)   m_ov = 1;
        else if (oclr) m_ov = 0;
    endtask

    task automatic compare_all();
        check("valid", 32'(bus.valid_o), 32'(m_outq.size() != 0));
        if (m_outq.size() != 0)
            check("angle_negate", 32'({bus.negate_o, bus.angle_o}), 32'(m_outq[0]));
        check("wrap", 32'(bus.wrap_o), 32'(m_wrap));
        check("overrun", 32'(bus.overrun_o), 32'(m_ov));
    endtask

    task automatic step(input bit en, input bit stb, input int inc,
                        input bit clr, input bit rdy, input bit oclr);
        bus.enable_i      = en;
        bus.strobe_i      = stb;
        bus.phase_inc_i   = BW'(inc);
        bus.phase_clr_i   = clr;
        bus.ready_i       = rdy;
        bus.overrun_clr_i = oclr;
        @(posedge clk_i);
        model_edge(en, stb, inc, clr, rdy, oclr);
        #1;
        compare_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_angle"},   32'(bus.angle_o),   32'h0);
        check({tag, "_negate"},  32'(bus.negate_o),  32'h0);
        check({tag, "_valid"},   32'(bus.valid_o),   32'h0);
        check({tag, "_wrap"},    32'(bus.wrap_o),    32'h0);
        check({tag, "_overrun"}, 32'(bus.overrun_o), 32'h0);
    endtask

    int seq_tab [8] = '{32'h000, 32'h020, 32'h1C0, 32'h1E0, 32'h100, 32'h120, 32'h0C0, 32'h0E0};

    initial begin
        bus.enable_i = 0; bus.strobe_i = 0; bus.phase_inc_i = '0;
        bus.phase_clr_i = 0; bus.ready_i = 0; bus.overrun_clr_i = 0;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk_i);
        rst_i = 1'b1;

        // Eight strobes of 0x20 sweep the full circle
        step(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 'h20, 0, 1, 0);
            check("sweep_angle", 32'({bus.negate_o, bus.angle_o}), 32'(seq_tab[i]));
            check("sweep_wrap", 32'(bus.wrap_o), 32'(i == 7));
        end
        step(1, 1, 0, 0, 1, 0);
        check("sweep_back_to_zero", 32'({bus.negate_o, bus.angle_o}), 32'h0);

        // Back-pressure: second strobe is dropped and flags overrun
        step(1, 0, 0, 0, 1, 0);
        step(1, 1, 'h10, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0, 0);
        step(1, 1, 'h10, 0, 0, 0);
        check("overrun_set", 32'(bus.overrun_o), 32'h1);
        check("held_output", 32'({bus.negate_o, bus.angle_o}), 32'h0);
        step(1, 0, 0, 0, 0, 1);
        check("overrun_cleared", 32'(bus.overrun_o), 32'h0);

        // Strobe with ready in PENDING reloads next sample
        step(1, 1, 'h30, 0, 1, 0);
        check("reload_sample", 32'({bus.negate_o, bus.angle_o}), 32'h010);
        check("reload_valid", 32'(bus.valid_o), 32'h1);

        // Clear coincident with strobe at phase 0x60
        step(1, 0, 0, 1, 1, 0);
        step(1, 1, 'h60, 0, 1, 0);
        step(1, 1, 'h10, 1, 0, 0);
        check("clr_no_wrap", 32'(bus.wrap_o), 32'h0);
        check("clr_valid_kept", 32'(bus.valid_o), 32'h1);
        step(1, 1, 'h10, 0, 1, 0);
        check("clr_phase_zero", 32'({bus.negate_o, bus.angle_o}), 32'h0);

        // Disable while PENDING keeps the phase
        step(0, 0, 0, 0, 0, 0);
        check("disable_valid", 32'(bus.valid_o), 32'h0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 'h40, 0, 0, 0);
        check("retained_phase", 32'({bus.negate_o, bus.angle_o}), 32'h010);

        // Asynchronous reset mid-cycle while PENDING
        #3;
        rst_i = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b1;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 19) != 0,
                 $urandom_range(0, 9) < 4,
                 int'($urandom_range(0, FULL - 1)),
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 14) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
